// File: rtl/md_bus_register.sv
// Memory data register: loads from the internal bus or via a req/ack memory read
// with lane extraction, sign/zero extension and a timeout. It also drives the store lanes.
module md_bus_register #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16,
  localparam int unsigned LANES  = DATA_W / 8,
  localparam int unsigned OFF_W  = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en_bus,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              rd_start,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [OFF_W-1:0]  addr_lo,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [LANES-1:0]  mem_be
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {StIdle, StWait} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  q_q, q_d;
  logic               req_q, req_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         sz_q, sz_d;
  logic               sext_q, sext_d;
  logic [OFF_W-1:0]   off_q, off_d;

  // A dword request on a 32-bit datapath is treated as a word.
  function automatic logic [1:0] eff_size(input logic [1:0] s);
    if (DATA_W == 32 && s == 2'b11) return 2'b10;
    return s;
  endfunction

  function automatic logic is_aligned(input logic [1:0] s, input logic [OFF_W-1:0] off);
    logic [OFF_W-1:0] m;
    m = OFF_W'((1 << s) - 1);
    return (off & m) == '0;
  endfunction

  // Read-data extraction from the latched size/offset/sign mode.
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext;
  logic              fill;
  int                nbits;

  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    nbits   = 8 << sz_q;
    unique case (sz_q)
      2'b00:   fill = sext_q & shifted[7];
      2'b01:   fill = sext_q & shifted[15];
      2'b10:   fill = sext_q & shifted[31];
      default: fill = sext_q & shifted[DATA_W-1];
    endcase
    for (int i = 0; i < DATA_W; i++) begin
      ext[i] = (i < nbits) ? shifted[i] : fill;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    req_d   = req_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    sz_d    = sz_q;
    sext_d  = sext_q;
    off_d   = off_q;
    unique case (state_q)
      StIdle: begin
        if (rd_start) begin
          sz_d   = eff_size(size);
          sext_d = sext;
          off_d  = addr_lo;
          cnt_d  = '0;
          if (is_aligned(eff_size(size), addr_lo)) begin
            state_d = StWait;
            req_d   = 1'b1;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (en_bus) begin
          q_d = bus_in;
        end
      end
      StWait: begin
        if (mem_ack) begin
          q_d     = ext;
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (TIMEOUT != 0) begin
          if (32'(cnt_q) + 32'd1 == TIMEOUT) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
      q_q     <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      sz_q    <= 2'b00;
      sext_q  <= 1'b0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      sz_q    <= sz_d;
      sext_q  <= sext_d;
      off_q   <= off_d;
    end
  end

  // Store path follows the live size/offset, not the latched read parameters.
  logic [1:0] st_sz;
  logic       st_ok;

  always_comb begin
    st_sz = eff_size(size);
    st_ok = is_aligned(st_sz, addr_lo);
    unique case (st_sz)
      2'b00:   mem_wdata = {LANES{q_q[7:0]}};
      2'b01:   mem_wdata = {(LANES / 2){q_q[15:0]}};
      2'b10:   mem_wdata = {(DATA_W / 32){q_q[31:0]}};
      default: mem_wdata = q_q;
    endcase
    for (int l = 0; l < LANES; l++) begin
      mem_be[l] = st_ok && (l >= int'(addr_lo)) && (l < int'(addr_lo) + (1 << st_sz));
    end
  end

  assign q       = q_q;
  assign mem_req = req_q;
  assign busy    = (state_q == StWait);
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_md_bus_register.sv
// Bench for md_bus_register: directed literal cases plus random traffic against
// a transaction-level model, compared on every falling clock edge.
module tb_md_bus_register;

  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          en_bus = 1'b0;
  logic [DW-1:0] bus_in = '0;
  logic          rd_start = 1'b0;
  logic [1:0]    size = 2'b00;
  logic          sext = 1'b0;
  logic [1:0]    addr_lo = 2'b00;
  logic          mem_req;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] q;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;

  md_bus_register #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .clr       (clr),
    .en_bus    (en_bus),
    .bus_in    (bus_in),
    .rd_start  (rd_start),
    .size      (size),
    .sext      (sext),
    .addr_lo   (addr_lo),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model state
  logic [31:0] m_q;
  bit          m_busy, m_done, m_err, m_sx;
  int          m_cnt, m_nb, m_off;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b11) ? 4 : (1 << s);
  endfunction

  function automatic logic [31:0] m_extract(input logic [31:0] rd, input int nb, input int off,
                                            input bit sx);
    logic [31:0] mask, v;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 1);
    v    = (rd >> (8 * off)) & mask;
    if (sx && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] r, input logic [1:0] s);
    logic [31:0] w;
    int nb;
    nb = nbytes(s);
    for (int k = 0; k < 4; k++) w[8 * k +: 8] = r[8 * (k % nb) +: 8];
    return w;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] s, input logic [1:0] off);
    int nb;
    nb = nbytes(s);
    if (int'(off) % nb != 0) return 4'b0000;
    return 4'(((1 << nb) - 1) << off);
  endfunction

  task automatic model_reset();
    m_q = '0; m_busy = 0; m_done = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    if (!clr) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (!m_busy) begin
      if (rd_start) begin
        m_nb = nbytes(size); m_off = int'(addr_lo); m_sx = sext;
        if (m_off % m_nb == 0) begin
          m_err = 0; m_busy = 1; m_cnt = 0;
        end else begin
          m_err = 1;
        end
      end else if (en_bus) begin
        m_q = bus_in;
      end
    end else if (mem_ack) begin
      m_q = m_extract(mem_rdata, m_nb, m_off, m_sx);
      m_busy = 0; m_done = 1;
    end else begin
      m_cnt++;
      if (TO != 0 && m_cnt == TO) begin
        m_busy = 0; m_err = 1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("q", q, m_q);
      chk("mem_req", 32'(mem_req), 32'(m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("mem_wdata", mem_wdata, exp_wdata(m_q, size));
      chk("mem_be", 32'(mem_be), 32'(exp_be(size, addr_lo)));
    end
  end

  int busy_cnt, done_cnt, req_cnt;
  bit req_seen;
  int mode;

  initial begin
    model_reset();
    cyc();
    chk("reset_q", q, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_req", 32'(mem_req), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    #2;
    clr = 1'b1;
    cmp_en = 1'b1;

    // Bus load
    en_bus = 1; bus_in = 32'hDEADBEEF;
    cyc();
    en_bus = 0;
    chk("bus_load_q", q, 32'hDEADBEEF);
    chk("bus_load_done", 32'(done), 32'h0);

    // Signed byte load, ack on the fourth edge after start
    size = 2'b00; sext = 1; addr_lo = 2; rd_start = 1;
    cyc();
    rd_start = 0;
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (k == 3) begin
        mem_ack = 1; mem_rdata = 32'h0080FF11;
      end
      cyc();
    end
    mem_ack = 0;
    chk("byte_q", q, 32'hFFFFFF80);
    chk("byte_done", 32'(done), 32'h1);
    chk("byte_busy_after", 32'(busy), 32'h0);
    chk("byte_busy_cycles", 32'(busy_cnt), 32'd4);
    cyc();
    if (done) done_cnt++;
    chk("byte_done_pulses", 32'(done_cnt), 32'd0);

    // Half zero-extend, minimum latency
    size = 2'b01; sext = 0; addr_lo = 2; rd_start = 1;
    cyc();
    rd_start = 0; mem_ack = 1; mem_rdata = 32'h8001_1234;
    cyc();
    mem_ack = 0;
    chk("half_q", q, 32'h00008001);
    chk("half_done", 32'(done), 32'h1);

    // Misaligned half
    size = 2'b01; addr_lo = 1; rd_start = 1;
    cyc();
    rd_start = 0;
    chk("misalign_err", 32'(err), 32'h1);
    req_seen = 0;
    for (int k = 0; k < 3; k++) begin
      if (mem_req) req_seen = 1;
      cyc();
    end
    chk("misalign_no_req", 32'(req_seen), 32'h0);
    chk("misalign_err_sticky", 32'(err), 32'h1);

    // Word timeout; bus loads during WAIT must be ignored
    size = 2'b10; addr_lo = 0; rd_start = 1;
    cyc();
    rd_start = 0; en_bus = 1; bus_in = 32'h12345678;
    chk("timeout_err_cleared", 32'(err), 32'h0);
    req_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!mem_req) break;
      req_cnt++;
      cyc();
    end
    en_bus = 0;
    chk("timeout_req_cycles", 32'(req_cnt), 32'd16);
    chk("timeout_err", 32'(err), 32'h1);
    chk("timeout_q", q, 32'h00008001);

    // Store lanes
    en_bus = 1; bus_in = 32'h000000AB;
    cyc();
    en_bus = 0; size = 2'b00; addr_lo = 3;
    #1;
    chk("store_wdata_b", mem_wdata, 32'hABABABAB);
    chk("store_be_b", 32'(mem_be), 32'b1000);
    size = 2'b01; addr_lo = 1;
    #1;
    chk("store_be_mis", 32'(mem_be), 32'b0000);
    addr_lo = 2;
    #1;
    chk("store_wdata_h", mem_wdata, 32'h00AB00AB);
    chk("store_be_h", 32'(mem_be), 32'b1100);

    // Async reset mid-WAIT, later ack ignored
    size = 2'b10; addr_lo = 0; rd_start = 1;
    cyc();
    rd_start = 0;
    #2;
    clr = 0;
    model_reset();
    #1;
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_q", q, 32'h0);
    cyc();
    #2;
    clr = 1;
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    cyc();
    cyc();
    mem_ack = 0;
    chk("rst_late_ack_q", q, 32'h0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      mode      = (c / 250) % 3;
      en_bus    = 1'($urandom_range(0, 1));
      bus_in    = $urandom;
      rd_start  = ($urandom_range(0, 3) == 0);
      size      = 2'($urandom_range(0, 3));
      sext      = 1'($urandom_range(0, 1));
      addr_lo   = 2'($urandom_range(0, 3));
      mem_ack   = (mode == 2) ? 1'b0 : ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      if (c % 700 == 350) begin
        clr = 0;
        model_reset();
        #2;
        clr = 1;
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
